// File: rtl/pc_sel_if.sv
// pc_sel_if: request/status bundle between the fetch-side controller and
// pc_sel_unit.
//
//   master modport (controller): drives stall, br_taken, br_target, jmp, call,
//                                ret, jmp_target; observes pc, ras_depth,
//                                ras_ovf, ras_unf.
//   slave modport (pc_sel_unit): the mirror image.
//
// With PC_IRQ_EN defined the bundle also carries irq (master -> slave) and
// irq_ack (slave -> master).
interface pc_sel_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             stall;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             jmp;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] jmp_target;
    logic [WIDTH-1:0] pc;
    logic [DW-1:0]    ras_depth;
    logic             ras_ovf;
    logic             ras_unf;
`ifdef PC_IRQ_EN
    logic             irq;
    logic             irq_ack;
`endif

    modport master (
        output stall, br_taken, br_target, jmp, call, ret, jmp_target,
        input  pc, ras_depth, ras_ovf, ras_unf
`ifdef PC_IRQ_EN
        , output irq
        , input  irq_ack
`endif
    );

    modport slave (
        input  stall, br_taken, br_target, jmp, call, ret, jmp_target,
        output pc, ras_depth, ras_ovf, ras_unf
`ifdef PC_IRQ_EN
        , input  irq
        , output irq_ack
`endif
    );
endinterface

// File: rtl/pc_sel_unit.sv
// pc_sel_unit: next-PC select, program-counter register and a DEPTH-entry
// circular return-address stack (RAS).
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous reset, active low
//   bus    - pc_sel_if.slave: stall / ret / call / jmp / br_taken requests in
//            (priority in that order, sequential otherwise), registered pc,
//            ras_depth and one-cycle ras_ovf / ras_unf pulses out.
//
// Optional feature: macro PC_IRQ_EN adds irq / irq_ack and the IRQ_VEC
// parameter. An interrupt outranks every request except stall, pushes the
// current pc (the interrupted instruction) and vectors to IRQ_VEC.
module pc_sel_unit #(
    parameter int               WIDTH    = 16,
    parameter int               INC      = 1,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 4
`ifdef PC_IRQ_EN
    , parameter logic [WIDTH-1:0] IRQ_VEC = WIDTH'(16'h0008)
`endif
) (
    input logic     clk,
    input logic     rst_n,
    pc_sel_if.slave bus
);
    localparam int               PW    = $clog2(DEPTH);
    localparam int               DW    = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    wp_q, wp_d;       // next free slot; top lives at wp_q-1
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
`ifdef PC_IRQ_EN
    logic             ack_q, ack_d;
`endif

    logic [WIDTH-1:0] ras_q [DEPTH];
    logic             ras_we;
    logic [PW-1:0]    ras_widx;
    logic [WIDTH-1:0] ras_wdata;

    logic             do_push;
    logic [WIDTH-1:0] push_val;

    logic [WIDTH-1:0] pc_inc;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    wp_inc;
    logic             ras_full;
    logic             ras_empty;

    // Pointer arithmetic wraps explicitly so DEPTH need not be a power of two.
    assign pc_inc    = pc_q + INC_W;
    assign top_idx   = (wp_q == '0) ? PW'(DEPTH - 1) : wp_q - 1'b1;
    assign wp_inc    = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
    assign ras_full  = (depth_q == DW'(DEPTH));
    assign ras_empty = (depth_q == '0);

    always_comb begin
        // NOTE: every signal gets a default before the if/else chain so no
        // path leaves one unassigned and no latch is inferred.
        pc_d      = pc_inc;
        wp_d      = wp_q;
        depth_d   = depth_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
`ifdef PC_IRQ_EN
        ack_d     = 1'b0;
`endif
        ras_we    = 1'b0;
        ras_widx  = wp_q;
        ras_wdata = pc_inc;
        do_push   = 1'b0;
        push_val  = pc_inc;

        if (bus.stall) begin
            pc_d = pc_q;
        end
`ifdef PC_IRQ_EN
        else if (bus.irq) begin
            do_push  = 1'b1;
            push_val = pc_q;
            pc_d     = IRQ_VEC;
            ack_d    = 1'b1;
        end
`endif
        else if (bus.ret && bus.call && !ras_empty) begin
            // Pop and push cancel: replace the top in place, depth unchanged.
            pc_d      = ras_q[top_idx];
            ras_we    = 1'b1;
            ras_widx  = top_idx;
            ras_wdata = pc_inc;
        end else if (bus.ret && !bus.call) begin
            if (ras_empty) begin
                unf_d = 1'b1;
            end else begin
                pc_d    = ras_q[top_idx];
                wp_d    = top_idx;
                depth_d = depth_q - 1'b1;
            end
        end else if (bus.call) begin
            // Also reached by call+ret on an empty stack, which flags underflow.
            do_push = 1'b1;
            pc_d    = bus.jmp_target;
            unf_d   = bus.ret;
        end else if (bus.jmp) begin
            pc_d = bus.jmp_target;
        end else if (bus.br_taken) begin
            pc_d = bus.br_target;
        end

        // A push into a full stack lands on the oldest slot (wp_q == oldest
        // when full), so the circular buffer silently discards it.
        if (do_push) begin
            ras_we    = 1'b1;
            ras_widx  = wp_q;
            ras_wdata = push_val;
            wp_d      = wp_inc;
            if (ras_full) begin
                ovf_d = 1'b1;
            end else begin
                depth_d = depth_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            wp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
`ifdef PC_IRQ_EN
            ack_q   <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
            wp_q    <= wp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
`ifdef PC_IRQ_EN
            ack_q   <= ack_d;
`endif
        end
    end

    // NOTE: the RAS storage is deliberately not reset; clearing depth and the
    // pointer already makes every entry invalid, and an unreset array maps
    // onto plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_q[ras_widx] <= ras_wdata;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.ras_depth = depth_q;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
`ifdef PC_IRQ_EN
    assign bus.irq_ack   = ack_q;
`endif
endmodule

// File: tb/tb_pc_sel_unit.sv
// tb_pc_sel_unit: directed scenarios with literal expectations, then
// randomized requests, all compared every cycle against a queue-based
// model of the PC / return-address stack.
module tb_pc_sel_unit;
    localparam int          WIDTH    = 16;
    localparam int          DEPTH    = 4;
    localparam int          INC      = 1;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          IRQ_VEC  = 'h0008;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_sel_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pc_sel_unit #(
        .WIDTH   (WIDTH),
        .INC     (INC),
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_pc;
    int m_ras[$];          // back = newest entry
    bit m_ovf, m_unf, m_ack;
    bit chk_en = 1'b0;

    function automatic void m_push(int val);
        if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
        end
        m_ras.push_back(val);
    endfunction

    function automatic void model_step();
        int nxt;
        bit irq_in;
        nxt    = (m_pc + INC) % 65536;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_ack  = 1'b0;
        irq_in = 1'b0;
`ifdef PC_IRQ_EN
        irq_in = bus.irq;
`endif
        if (!rst_n) begin
            m_pc = RESET_PC;
            m_ras.delete();
        end else if (bus.stall) begin
            // hold
        end else if (irq_in) begin
            m_push(m_pc);
            m_pc  = IRQ_VEC;
            m_ack = 1'b1;
        end else if (bus.ret && bus.call) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras[m_ras.size() - 1];
                m_ras[m_ras.size() - 1] = nxt;
            end else begin
                m_push(nxt);
                m_pc  = bus.jmp_target;
                m_unf = 1'b1;
            end
        end else if (bus.ret) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin
                m_pc  = nxt;
                m_unf = 1'b1;
            end
        end else if (bus.call) begin
            m_push(nxt);
            m_pc = bus.jmp_target;
        end else if (bus.jmp)      m_pc = bus.jmp_target;
        else if (bus.br_taken)     m_pc = bus.br_target;
        else                       m_pc = nxt;
    endfunction

    always @(posedge clk) model_step();

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", bus.pc, m_pc);
            check("ras_depth", bus.ras_depth, m_ras.size());
            check("ras_ovf", bus.ras_ovf, m_ovf);
            check("ras_unf", bus.ras_unf, m_unf);
`ifdef PC_IRQ_EN
            check("irq_ack", bus.irq_ack, m_ack);
`endif
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a falling edge: apply one request, return after the
    // next falling edge so its effect is visible.
    task automatic drive(bit st, bit br, logic [15:0] bt, bit j, bit c, bit r,
                         logic [15:0] jt, bit irq_req = 1'b0);
        bus.stall      = st;
        bus.br_taken   = br;
        bus.br_target  = bt;
        bus.jmp        = j;
        bus.call       = c;
        bus.ret        = r;
        bus.jmp_target = jt;
`ifdef PC_IRQ_EN
        bus.irq        = irq_req;
`else
        if (irq_req) $display("irq request ignored: PC_IRQ_EN not defined");
`endif
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 16'h0, 0, 0, 0, 16'h0);
    endtask

    task automatic jump(logic [15:0] t);
        drive(0, 0, 16'h0, 1, 0, 0, t);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.stall = 0; bus.br_taken = 0; bus.br_target = '0; bus.jmp = 0;
        bus.call = 0; bus.ret = 0; bus.jmp_target = '0;
`ifdef PC_IRQ_EN
        bus.irq = 0;
`endif
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("reset_pc", bus.pc, 16'h0000);
        check("reset_depth", bus.ras_depth, 0);
        check("reset_flags", {bus.ras_ovf, bus.ras_unf}, 2'b00);

        for (int i = 1; i <= 3; i++) begin
            idle();
            check("seq_pc", bus.pc, i);
        end

        // call / ret round trip
        jump(16'h0010);
        drive(0, 0, 16'h0, 0, 1, 0, 16'h0100);
        check("call_pc", bus.pc, 16'h0100);
        check("call_depth", bus.ras_depth, 1);
        drive(0, 0, 16'h0, 0, 0, 1, 16'h0);
        check("ret_pc", bus.pc, 16'h0011);
        check("ret_depth", bus.ras_depth, 0);

        // overflow then underflow
        jump(16'h0020);
        for (int k = 1; k <= 5; k++) drive(0, 0, 16'h0, 0, 1, 0, 16'(k * 'h100));
        check("ovf_pulse", bus.ras_ovf, 1);
        check("ovf_depth", bus.ras_depth, 4);
        for (int k = 4; k >= 1; k--) begin
            drive(0, 0, 16'h0, 0, 0, 1, 16'h0);
            check("ret_order", bus.pc, 16'(k * 'h100 + 1));
        end
        drive(0, 0, 16'h0, 0, 0, 1, 16'h0);
        check("unf_pulse", bus.ras_unf, 1);
        check("unf_pc", bus.pc, 16'h0102);

        // wrap and stall
        jump(16'hFFFF);
        idle();
        check("wrap_pc", bus.pc, 16'h0000);
        drive(1, 1, 16'h1234, 0, 0, 0, 16'h0);
        check("stall_pc", bus.pc, 16'h0000);

        // priority jmp over branch
        drive(0, 1, 16'h0300, 1, 0, 0, 16'h0200);
        check("jmp_over_br", bus.pc, 16'h0200);

        // ret+call together
        jump(16'h004F);
        drive(0, 0, 16'h0, 0, 1, 0, 16'h0040);
        drive(0, 0, 16'h0, 0, 1, 1, 16'h0777);
        check("retcall_pc", bus.pc, 16'h0050);
        check("retcall_depth", bus.ras_depth, 1);
        drive(0, 0, 16'h0, 0, 0, 1, 16'h0);
        check("retcall_top", bus.pc, 16'h0041);

        // reset mid-sequence discards stack
        drive(0, 0, 16'h0, 0, 1, 0, 16'h0500);
        drive(0, 0, 16'h0, 0, 1, 0, 16'h0600);
        rst_n = 1'b0;
        drive(1, 0, 16'h0, 0, 0, 0, 16'h0);
        rst_n = 1'b1;
        check("midrst_pc", bus.pc, 16'h0000);
        check("midrst_depth", bus.ras_depth, 0);
        drive(0, 0, 16'h0, 0, 0, 1, 16'h0);
        check("midrst_unf", bus.ras_unf, 1);

`ifdef PC_IRQ_EN
        jump(16'h0030);
        drive(0, 0, 16'h0, 0, 1, 0, 16'h0123, 1'b1);
        check("irq_pc", bus.pc, 16'h0008);
        check("irq_ack", bus.irq_ack, 1);
        drive(0, 0, 16'h0, 0, 0, 1, 16'h0);
        check("irq_ret", bus.pc, 16'h0030);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            drive($urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0, 16'($urandom),
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, 16'($urandom),
                  $urandom_range(0, 9) == 0);
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
